snn_layer_seq: RTL



---
 rtl/snn_layer_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/snn_layer_seq.sv
// Sequencer for one fully-connected SNN layer pass: walks NUM_OUT neurons x NUM_IN inputs,
// drives memory addresses and MAC controls, writes activations back and tracks their argmax.
module snn_layer_seq #(
    parameter int NUM_IN  = 784,
    parameter int NUM_OUT = 32,
    parameter int IN_AW   = $clog2(NUM_IN),
    parameter int WT_AW   = $clog2(NUM_IN * NUM_OUT),
    parameter int OUT_AW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [IN_AW-1:0]         in_addr,
    output logic [WT_AW-1:0]         wt_addr,
    output logic                     mac_clr,
    output logic                     mac_en,
    input  logic signed [7:0]        lut_q,
    output logic                     out_we,
    output logic [OUT_AW-1:0]        out_addr,
    output logic                     busy,
    output logic                     done,
    output logic [OUT_AW-1:0]        digit
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_MAC    = 3'd2;
    localparam logic [2:0] S_DRAIN1 = 3'd3;
    localparam logic [2:0] S_DRAIN2 = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [IN_AW-1:0]  I_LAST  = IN_AW'(NUM_IN - 1);
    localparam logic [OUT_AW-1:0] N_LAST  = OUT_AW'(NUM_OUT - 1);
    localparam logic [WT_AW-1:0]  WT_STEP = WT_AW'(NUM_IN);

    logic [2:0]          state;
    logic [IN_AW-1:0]    i_cnt;
    logic [OUT_AW-1:0]   n_cnt;
    logic [WT_AW-1:0]    wt_base;
    logic signed [7:0]   best_val;
    logic [OUT_AW-1:0]   best_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            i_cnt    <= '0;
            n_cnt    <= '0;
            wt_base  <= '0;
            best_val <= 8'sh80;
            best_idx <= '0;
            digit    <= '0;
            mac_en   <= 1'b0;
        end else begin
            // memories have one cycle of read latency, so the MAC enable trails the address phase
            mac_en <= (state == S_MAC);
            case (state)
                S_IDLE: begin
                    i_cnt    <= '0;
                    n_cnt    <= '0;
                    wt_base  <= '0;
                    best_val <= 8'sh80;
                    best_idx <= '0;
                    if (start) state <= S_CLR;
                end
                S_CLR: begin
                    i_cnt <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (i_cnt == I_LAST) state <= S_DRAIN1;
                    else                 i_cnt <= i_cnt + IN_AW'(1);
                end
                S_DRAIN1: state <= S_DRAIN2;
                S_DRAIN2: state <= S_WRITE;
                S_WRITE: begin
                    // strict compare keeps the lower index on ties
                    if (n_cnt == '0 || lut_q > best_val) begin
                        best_val <= lut_q;
                        best_idx <= n_cnt;
                    end
                    if (n_cnt == N_LAST) begin
                        state <= S_DONE;
                    end else begin
                        n_cnt   <= n_cnt + OUT_AW'(1);
                        wt_base <= wt_base + WT_STEP;
                        state   <= S_CLR;
                    end
                end
                S_DONE: begin
                    digit <= best_idx;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_addr  = (state == S_MAC) ? i_cnt : '0;
    assign wt_addr  = (state == S_MAC) ? wt_base + WT_AW'(i_cnt) : '0;
    assign mac_clr  = (state == S_CLR);
    assign out_we   = (state == S_WRITE);
    assign out_addr = (state == S_WRITE) ? n_cnt : '0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

endmodule
